// File: rtl/traffic_phase_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_fsm
//  Purpose  : Multi-approach traffic phase sequencer. It latches demand per
//             phase, skips idle approaches, rests in main green when nothing
//             else is pending, and serves pedestrian walk after main yellow.
//             Optional all-red clearance (TRAFFIC_ALL_RED_CLEAR_EN) inserts
//             ALL_RED with the CLR interval after every yellow.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_phase_fsm #(
   parameter int NUM_PHASES = 2
) (
   input  logic                  clk,
   input  logic                  sys_reset,
   input  logic                  prg_sync_in,
   input  logic [NUM_PHASES-1:0] sensor_sync_in,
   input  logic                  walkRegister_status,
   input  logic                  expired,
   output logic                  start_timer,
   output logic [1:0]            interval_address,
   output logic                  walkRegister_reset,
   output logic [3*NUM_PHASES:0] light_signals,
   output logic [2:0]            current_phase
);

   localparam int LW = 3*NUM_PHASES+1;

   localparam logic [1:0] ADDR_BASE = 2'b00;
   localparam logic [1:0] ADDR_EXT  = 2'b01;
   localparam logic [1:0] ADDR_YEL  = 2'b10;
`ifdef TRAFFIC_ALL_RED_CLEAR_EN
   localparam logic [1:0] ADDR_CLR  = 2'b11;
`endif

   // Phase 0 never carries latched demand; this mask drops it from "pending".
   localparam logic [NUM_PHASES-1:0] NON_MAIN = {{(NUM_PHASES-1){1'b1}}, 1'b0};

`ifdef TRAFFIC_ALL_RED_CLEAR_EN
   typedef enum logic [2:0] {
      GREEN_START = 3'd0,
      GREEN_EXT   = 3'd1,
      YELLOW      = 3'd2,
      ALL_RED     = 3'd3,
      WALK        = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      GREEN_START = 3'd0,
      GREEN_EXT   = 3'd1,
      YELLOW      = 3'd2,
      WALK        = 3'd4
   } state_t;
`endif

   state_t                state_q, state_d;
   logic [2:0]            phase_q, phase_d;
   logic [1:0]            addr_q, addr_d;
   logic                  start_q;
   logic                  wrst_q, wrst_d;
   logic [NUM_PHASES-1:0] dem_q, dem_d;
   logic [LW-1:0]         lights_q, lights_d;

   logic                  w_pending;
   logic                  w_cur_sensor;
   logic [NUM_PHASES-1:0] w_green;
   logic [2:0]            w_target;
   logic                  w_resolve;
   logic                  w_advance;

   // Lamp pattern for a given state and served phase: served phase G or Y,
   // everyone else red; WALK lamp only in the WALK state.
   function automatic logic [LW-1:0] decode_lights(state_t st, logic [2:0] ph);
      logic [LW-1:0] l;
      l = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         if (ph == 3'(k) && (st == GREEN_START || st == GREEN_EXT))
            l[3*k+1 +: 3] = 3'b001;
         else if (ph == 3'(k) && st == YELLOW)
            l[3*k+1 +: 3] = 3'b010;
         else
            l[3*k+1 +: 3] = 3'b100;
      end
      l[0] = (st == WALK);
      return l;
   endfunction

   assign w_pending = |((dem_q | sensor_sync_in) & NON_MAIN);

   // Sensor of the served phase and which phase is currently showing green.
   always_comb begin
      w_cur_sensor = 1'b0;
      w_green      = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         if (phase_q == 3'(k)) begin
            w_cur_sensor = sensor_sync_in[k];
            w_green[k]   = (state_q == GREEN_START) || (state_q == GREEN_EXT);
         end
      end
   end

   // Lowest demanded phase above the current one; wraps to main road if none.
   always_comb begin
      w_target = 3'd0;
      for (int j = NUM_PHASES-1; j >= 1; j--) begin
         if (3'(j) > phase_q && (dem_q[j] || sensor_sync_in[j]))
            w_target = 3'(j);
      end
   end

   // Next-state decision; only an expiry moves the sequencer.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      addr_d    = addr_q;
      wrst_d    = 1'b0;
      w_resolve = 1'b0;
      w_advance = 1'b0;
      if (expired) begin
         case (state_q)
            GREEN_START: begin
               if (phase_q == 3'd0 && !w_pending && !walkRegister_status) begin
                  addr_d = ADDR_BASE;
               end else if (w_cur_sensor) begin
                  state_d = GREEN_EXT;
                  addr_d  = ADDR_EXT;
               end else begin
                  state_d = YELLOW;
                  addr_d  = ADDR_YEL;
               end
            end
            GREEN_EXT: begin
               state_d = YELLOW;
               addr_d  = ADDR_YEL;
            end
            YELLOW: begin
`ifdef TRAFFIC_ALL_RED_CLEAR_EN
               state_d = ALL_RED;
               addr_d  = ADDR_CLR;
`else
               w_resolve = 1'b1;
`endif
            end
`ifdef TRAFFIC_ALL_RED_CLEAR_EN
            ALL_RED: begin
               w_resolve = 1'b1;
            end
`endif
            WALK: begin
               wrst_d    = 1'b1;
               w_advance = 1'b1;
            end
            default: begin
               state_d = GREEN_START;
               phase_d = 3'd0;
               addr_d  = ADDR_BASE;
            end
         endcase

         // Walk is only served on the way out of main road.
         if (w_resolve) begin
            if (phase_q == 3'd0 && walkRegister_status) begin
               state_d = WALK;
               addr_d  = ADDR_EXT;
            end else begin
               w_advance = 1'b1;
            end
         end

         if (w_advance) begin
            state_d = GREEN_START;
            phase_d = w_target;
            addr_d  = ADDR_BASE;
         end
      end
   end

   // Demand latch: remember sensors of non-green phases, forget on entering green.
   always_comb begin
      dem_d = dem_q | (sensor_sync_in & ~w_green & NON_MAIN);
      if (expired && state_d == GREEN_START) begin
         for (int k = 0; k < NUM_PHASES; k++) begin
            if (phase_d == 3'(k))
               dem_d[k] = 1'b0;
         end
      end
   end

   assign lights_d = decode_lights(state_d, phase_d);

   // All state and outputs; reprogram acts exactly like reset and beats expiry.
   always_ff @(posedge clk) begin
      if (sys_reset || prg_sync_in) begin
         state_q  <= GREEN_START;
         phase_q  <= 3'd0;
         addr_q   <= ADDR_BASE;
         start_q  <= 1'b1;
         wrst_q   <= 1'b0;
         dem_q    <= '0;
         lights_q <= decode_lights(GREEN_START, 3'd0);
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         addr_q   <= addr_d;
         start_q  <= expired;
         wrst_q   <= wrst_d;
         dem_q    <= dem_d;
         lights_q <= lights_d;
      end
   end

   assign start_timer        = start_q;
   assign interval_address   = addr_q;
   assign walkRegister_reset = wrst_q;
   assign light_signals      = lights_q;
   assign current_phase      = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_phase_fsm
//  Purpose  : Self-checking bench for traffic_phase_fsm: directed vector table,
//             hand sequences for walk/reset corners, and randomized stimulus
//             against a behavioural phase-service model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_fsm;

   localparam int NP = 4;
   localparam int LW = 3*NP+1;
`ifdef TRAFFIC_ALL_RED_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   // Model service steps
   localparam int M_GREEN = 0;
   localparam int M_EXT   = 1;
   localparam int M_YEL   = 2;
   localparam int M_CLR   = 3;
   localparam int M_WALK  = 4;

   // Lamp words for NP=4: {ph3,ph2,ph1,ph0 as RYG}, WALK
   localparam logic [LW-1:0] G0 = 13'b100_100_100_001_0;
   localparam logic [LW-1:0] Y0 = 13'b100_100_100_010_0;
   localparam logic [LW-1:0] G1 = 13'b100_100_001_100_0;
   localparam logic [LW-1:0] Y1 = 13'b100_100_010_100_0;
   localparam logic [LW-1:0] G2 = 13'b100_001_100_100_0;
   localparam logic [LW-1:0] Y2 = 13'b100_010_100_100_0;
   localparam logic [LW-1:0] G3 = 13'b001_100_100_100_0;
   localparam logic [LW-1:0] Y3 = 13'b010_100_100_100_0;
   localparam logic [LW-1:0] RR = 13'b100_100_100_100_0;
   localparam logic [LW-1:0] WK = 13'b100_100_100_100_1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          sys_reset, prg_sync_in, walk, expired;
   logic [NP-1:0] sensor;
   logic          start_timer, wrst;
   logic [1:0]    addr;
   logic [LW-1:0] lights;
   logic [2:0]    phase;

   traffic_phase_fsm #(.NUM_PHASES(NP)) dut (
      .clk                (clk),
      .sys_reset          (sys_reset),
      .prg_sync_in        (prg_sync_in),
      .sensor_sync_in     (sensor),
      .walkRegister_status(walk),
      .expired            (expired),
      .start_timer        (start_timer),
      .interval_address   (addr),
      .walkRegister_reset (wrst),
      .light_signals      (lights),
      .current_phase      (phase)
   );

   // Two-approach instance for the basic resting check
   logic       d2_rst, d2_exp, d2_prg, d2_walk;
   logic [1:0] d2_sen;
   logic       d2_start, d2_wrst;
   logic [1:0] d2_addr;
   logic [6:0] d2_lights;
   logic [2:0] d2_phase;

   traffic_phase_fsm #(.NUM_PHASES(2)) dut2 (
      .clk                (clk),
      .sys_reset          (d2_rst),
      .prg_sync_in        (d2_prg),
      .sensor_sync_in     (d2_sen),
      .walkRegister_status(d2_walk),
      .expired            (d2_exp),
      .start_timer        (d2_start),
      .interval_address   (d2_addr),
      .walkRegister_reset (d2_wrst),
      .light_signals      (d2_lights),
      .current_phase      (d2_phase)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int m_st;
   int m_ph;
   bit m_dem [NP];
   bit e_start, e_wrst;
   logic [1:0] e_addr;

   function automatic logic [LW-1:0] exp_lights(int st, int ph);
      logic [LW-1:0] l;
      logic [2:0]    rgy;
      l = '0;
      for (int k = 0; k < NP; k++) begin
         rgy = 3'b100;
         if (k == ph && (st == M_GREEN || st == M_EXT)) rgy = 3'b001;
         else if (k == ph && st == M_YEL)               rgy = 3'b010;
         l[3*k+1 +: 3] = rgy;
      end
      l[0] = (st == M_WALK);
      return l;
   endfunction

   task automatic model_edge(bit rst, logic [NP-1:0] sen, bit wk, bit ex);
      int  nxt, ns, nph;
      bit  pend, leave, go;
      if (rst) begin
         m_st = M_GREEN; m_ph = 0;
         for (int k = 0; k < NP; k++) m_dem[k] = 1'b0;
         e_addr = 2'd0; e_start = 1'b1; e_wrst = 1'b0;
         return;
      end
      nxt = 0;
      for (int j = NP-1; j > m_ph; j--) if (m_dem[j] || sen[j]) nxt = j;
      pend = 1'b0;
      for (int j = 1; j < NP; j++) pend = pend | m_dem[j] | sen[j];
      ns = m_st; nph = m_ph; leave = 1'b0; go = 1'b0;
      e_start = ex; e_wrst = 1'b0;
      if (ex) begin
         case (m_st)
            M_GREEN: begin
               if (m_ph == 0 && !pend && !wk) e_addr = 2'd0;
               else if (sen[m_ph])            begin ns = M_EXT; e_addr = 2'd1; end
               else                           begin ns = M_YEL; e_addr = 2'd2; end
            end
            M_EXT:  begin ns = M_YEL; e_addr = 2'd2; end
            M_YEL:  begin
               if (CLR_EN) begin ns = M_CLR; e_addr = 2'd3; end
               else leave = 1'b1;
            end
            M_CLR:  leave = 1'b1;
            default: begin e_wrst = 1'b1; go = 1'b1; end
         endcase
         if (leave) begin
            if (m_ph == 0 && wk) begin ns = M_WALK; e_addr = 2'd1; end
            else go = 1'b1;
         end
         if (go) begin ns = M_GREEN; nph = nxt; e_addr = 2'd0; end
      end
      for (int k = 1; k < NP; k++)
         if (sen[k] && !(k == m_ph && (m_st == M_GREEN || m_st == M_EXT))) m_dem[k] = 1'b1;
      if (ex && ns == M_GREEN) m_dem[nph] = 1'b0;
      m_st = ns; m_ph = nph;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit            rst;
      logic [NP-1:0] sen;
      bit            wk;
      bit            ex;
      logic [1:0]    addr;
      logic [2:0]    ph;
      bit            st;
      bit            wr;
      logic [LW-1:0] li;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, logic [NP-1:0] sen, bit wk, bit ex,
                               logic [1:0] a, logic [2:0] ph, bit st, bit wr,
                               logic [LW-1:0] li);
      vec_t v;
      v.rst = rst; v.sen = sen; v.wk = wk; v.ex = ex;
      v.addr = a; v.ph = ph; v.st = st; v.wr = wr; v.li = li;
      vecs.push_back(v);
   endfunction

   task automatic apply(vec_t v, string tag);
      sys_reset = v.rst; prg_sync_in = 1'b0;
      sensor = v.sen; walk = v.wk; expired = v.ex;
      @(posedge clk);
      model_edge(v.rst, v.sen, v.wk, v.ex);
      #1;
      chk({tag, ".addr"},   32'(addr),        32'(v.addr));
      chk({tag, ".phase"},  32'(phase),       32'(v.ph));
      chk({tag, ".start"},  32'(start_timer), 32'(v.st));
      chk({tag, ".wrst"},   32'(wrst),        32'(v.wr));
      chk({tag, ".lights"}, 32'(lights),      32'(v.li));
   endtask

   task automatic rstep(bit r, bit use_prg, logic [NP-1:0] s, bit wk, bit ex);
      sys_reset = r & ~use_prg; prg_sync_in = r & use_prg;
      sensor = s; walk = wk; expired = ex;
      @(posedge clk);
      model_edge(r, s, wk, ex);
      #1;
      chk("rnd.addr",   32'(addr),        32'(e_addr));
      chk("rnd.phase",  32'(phase),       32'(m_ph));
      chk("rnd.start",  32'(start_timer), 32'(e_start));
      chk("rnd.wrst",   32'(wrst),        32'(e_wrst));
      chk("rnd.lights", 32'(lights),      32'(exp_lights(m_st, m_ph)));
   endtask

   initial begin
      bit            r, up, wk_r, ex;
      logic [NP-1:0] s;
      int            pulses;

      sys_reset = 1'b1; prg_sync_in = 1'b0; walk = 1'b0; expired = 1'b0; sensor = '0;
      d2_rst = 1'b1; d2_exp = 1'b0; d2_prg = 1'b0; d2_walk = 1'b0; d2_sen = 2'b00;

      // Two approaches, nothing requested: rests in main green across expiries
      @(posedge clk); #1;
      chk("t1.rst.start",  32'(d2_start),  32'd1);
      chk("t1.rst.lights", 32'(d2_lights), 32'(7'b100_001_0));
      d2_rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         d2_exp = 1'b1;
         @(posedge clk); #1;
         if (d2_start === 1'b1) pulses++;
         chk("t1.addr",   32'(d2_addr),   32'd0);
         chk("t1.phase",  32'(d2_phase),  32'd0);
         chk("t1.lights", 32'(d2_lights), 32'(7'b100_001_0));
         d2_exp = 1'b0;
         @(posedge clk); #1;
         chk("t1.start_low", 32'(d2_start), 32'd0);
      end
      chk("t1.pulses", 32'(pulses), 32'd5);

      // Skip idle phases: demand only on phase 2
      add(1, 4'b0000, 0, 0, 2'd0, 3'd0, 1, 0, G0);
      add(0, 4'b0100, 0, 0, 2'd0, 3'd0, 0, 0, G0);
      add(0, 4'b0000, 0, 1, 2'd2, 3'd0, 1, 0, Y0);
      add(0, 4'b0000, 0, 0, 2'd2, 3'd0, 0, 0, Y0);
      if (CLR_EN) add(0, 4'b0000, 0, 1, 2'd3, 3'd0, 1, 0, RR);
      add(0, 4'b0000, 0, 1, 2'd0, 3'd2, 1, 0, G2);
      add(0, 4'b0000, 0, 1, 2'd2, 3'd2, 1, 0, Y2);
      if (CLR_EN) add(0, 4'b0000, 0, 1, 2'd3, 3'd2, 1, 0, RR);
      add(0, 4'b0000, 0, 1, 2'd0, 3'd0, 1, 0, G0);
      add(0, 4'b0000, 0, 1, 2'd0, 3'd0, 1, 0, G0);
      // Sensor held on phase 1 extends its green
      add(0, 4'b0010, 0, 1, 2'd2, 3'd0, 1, 0, Y0);
      if (CLR_EN) add(0, 4'b0010, 0, 1, 2'd3, 3'd0, 1, 0, RR);
      add(0, 4'b0010, 0, 1, 2'd0, 3'd1, 1, 0, G1);
      add(0, 4'b0010, 0, 1, 2'd1, 3'd1, 1, 0, G1);
      add(0, 4'b0000, 0, 1, 2'd2, 3'd1, 1, 0, Y1);
      if (CLR_EN) add(0, 4'b0000, 0, 1, 2'd3, 3'd1, 1, 0, RR);
      add(0, 4'b0000, 0, 1, 2'd0, 3'd0, 1, 0, G0);
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "tbl");
      chk("t2.dem_clear", 32'(dut.dem_q), 32'd0);

      // Walk served after main yellow, then on to demanded phase 3
      vecs.delete();
      add(0, 4'b0000, 1, 1, 2'd2, 3'd0, 1, 0, Y0);
      if (CLR_EN) add(0, 4'b0000, 1, 1, 2'd3, 3'd0, 1, 0, RR);
      add(0, 4'b0000, 1, 1, 2'd1, 3'd0, 1, 0, WK);
      add(0, 4'b1000, 1, 0, 2'd1, 3'd0, 0, 0, WK);
      add(0, 4'b0000, 1, 1, 2'd0, 3'd3, 1, 1, G3);
      add(0, 4'b0000, 0, 0, 2'd0, 3'd3, 0, 0, G3);
      // Reset together with expiry during phase 3 yellow
      add(0, 4'b0000, 0, 1, 2'd2, 3'd3, 1, 0, Y3);
      add(0, 4'b0010, 0, 0, 2'd2, 3'd3, 0, 0, Y3);
      add(1, 4'b0000, 0, 1, 2'd0, 3'd0, 1, 0, G0);
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "seq");
      chk("t5.dem_clear", 32'(dut.dem_q), 32'd0);

      // Randomized traffic against the model
      wk_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 149) == 0);
         up = $urandom_range(0, 1);
         for (int k = 0; k < NP; k++) s[k] = ($urandom_range(0, 7) == 0);
         if (!wk_r) wk_r = ($urandom_range(0, 24) == 0);
         ex = ($urandom_range(0, 2) == 0);
         rstep(r, up, s, wk_r, ex);
         if (e_wrst) wk_r = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
